// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_cmp_pkg
// Description : FloPoCo 11/16 word layout, exception encodings and tag sizing
//               shared by the comparator scheduler and its core.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_cmp_pkg;

    localparam int WIDTH_DEF = 30;

    localparam int EXN_HI   = 29;
    localparam int EXN_LO   = 28;
    localparam int SIGN_BIT = 27;
    localparam int EXP_HI   = 26;
    localparam int EXP_LO   = 16;
    localparam int FRAC_HI  = 15;

    localparam logic [1:0] EXN_ZERO = 2'b00;
    localparam logic [1:0] EXN_NORM = 2'b01;
    localparam logic [1:0] EXN_INF  = 2'b10;
    localparam logic [1:0] EXN_NAN  = 2'b11;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_le_core.sv
`default_nettype none
// ============================================================================
// Module      : fp_le_core
// Description : Pipelined a - b on FloPoCo 11/16 words, reduced to the a <= b
//               decision from the exception and sign fields of the difference.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_le_core
    import fp_cmp_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CMP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_le
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       w_exn_a, w_exn_b, w_r_exn;
    logic             w_sgn_a, w_sgn_b, w_r_sgn;
    logic [27:0]      w_ext_a, w_ext_b, w_key_a, w_key_b;
    logic [28:0]      w_diff;
    logic             w_le;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    // Finite operands map to a signed key (zero -> 0) so one subtraction
    // yields the sign and zero-ness of the difference.
    always_comb begin
        w_exn_a = r_a[EXN_HI:EXN_LO];
        w_exn_b = r_b[EXN_HI:EXN_LO];
        w_sgn_a = r_a[SIGN_BIT];
        w_sgn_b = r_b[SIGN_BIT];
        w_ext_a = (w_exn_a == EXN_ZERO) ? '0 : {1'b0, r_a[EXP_HI:0]};
        w_ext_b = (w_exn_b == EXN_ZERO) ? '0 : {1'b0, r_b[EXP_HI:0]};
        w_key_a = w_sgn_a ? (~w_ext_a + 28'd1) : w_ext_a;
        w_key_b = w_sgn_b ? (~w_ext_b + 28'd1) : w_ext_b;
        w_diff  = {w_key_a[27], w_key_a} - {w_key_b[27], w_key_b};

        w_r_exn = EXN_NORM;
        w_r_sgn = w_diff[28];
        if (w_exn_a == EXN_NAN || w_exn_b == EXN_NAN) begin
            w_r_exn = EXN_NAN;
            w_r_sgn = 1'b0;
        end else if (w_exn_a == EXN_INF && w_exn_b == EXN_INF) begin
            w_r_exn = (w_sgn_a == w_sgn_b) ? EXN_NAN : EXN_INF;
            w_r_sgn = w_sgn_a;
        end else if (w_exn_a == EXN_INF) begin
            w_r_exn = EXN_INF;
            w_r_sgn = w_sgn_a;
        end else if (w_exn_b == EXN_INF) begin
            w_r_exn = EXN_INF;
            w_r_sgn = ~w_sgn_b;
        end else if (w_diff == '0) begin
            w_r_exn = EXN_ZERO;
            w_r_sgn = 1'b0;
        end

        case (w_r_exn)
            EXN_ZERO: w_le = 1'b1;
            EXN_NORM,
            EXN_INF:  w_le = w_r_sgn;
            default:  w_le = 1'b0;
        endcase
    end

    generate
        if (CMP_LAT == 1) begin : g_lat1
            assign o_le = w_le;
        end else begin : g_latn
            logic [CMP_LAT-2:0] r_le_sr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_le_sr <= '0;
                end else begin
                    r_le_sr[0] <= w_le;
                    for (int k = 1; k < CMP_LAT - 1; k++) begin
                        r_le_sr[k] <= r_le_sr[k-1];
                    end
                end
            end
            assign o_le = r_le_sr[CMP_LAT-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fp_cmp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_cmp_scheduler
// Description : Round-robin sharing of one pipelined a <= b comparator among
//               NUM_REQ requesters, with per-requester response registers.
//               Optional operand NaN flagging: define FP_CMP_SCHED_NAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_cmp_scheduler
    import fp_cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CMP_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [NUM_REQ-1:0]       rsp_le,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ-1:0]       rsp_nan,
    output logic                     busy
);

    localparam int TAG_W = tag_w(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] idx;
    } tag_t;

    logic [TAG_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_out;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0] r_rsp_le;
    tag_t               r_tag [CMP_LAT];

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_consume;
    logic [TAG_W:0]     w_cand;
    logic [TAG_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_core_le;
    logic               w_le_fin;
    tag_t               w_last;

    // Outstanding covers both the pipe and an unconsumed response.
    assign w_elig    = rst ? '0 : (req_valid & ~r_out);
    assign w_consume = r_rsp_valid & rsp_ready;

    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (TAG_W+1)'(k);
            if (w_cand >= (TAG_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (TAG_W+1)'(NUM_REQ);
            end
            if (!w_gnt_any && w_elig[w_cand[TAG_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[TAG_W-1:0];
            end
        end
        w_grant = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    end

    assign req_ready = w_grant;
    assign w_a       = req_a[w_gnt_idx*WIDTH +: WIDTH];
    assign w_b       = req_b[w_gnt_idx*WIDTH +: WIDTH];

    fp_le_core #(
        .WIDTH   (WIDTH),
        .CMP_LAT (CMP_LAT)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_le (w_core_le)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CMP_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_gnt_any;
            r_tag[0].idx   <= w_gnt_idx;
            for (int k = 1; k < CMP_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_last = r_tag[CMP_LAT-1];

`ifdef FP_CMP_SCHED_NAN_EN
    logic               w_nan_in;
    logic [CMP_LAT-1:0] r_nan_sr;
    logic [NUM_REQ-1:0] r_rsp_nan;

    assign w_nan_in = (w_a[EXN_HI:EXN_LO] == EXN_NAN) || (w_b[EXN_HI:EXN_LO] == EXN_NAN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nan_sr <= '0;
        end else begin
            r_nan_sr[0] <= w_nan_in;
            for (int k = 1; k < CMP_LAT; k++) begin
                r_nan_sr[k] <= r_nan_sr[k-1];
            end
        end
    end

    assign w_le_fin = w_core_le & ~r_nan_sr[CMP_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_nan <= '0;
        end else if (w_last.valid) begin
            r_rsp_nan[w_last.idx] <= r_nan_sr[CMP_LAT-1];
        end
    end

    assign rsp_nan = r_rsp_nan;
`else
    assign w_le_fin = w_core_le;
    assign rsp_nan  = '0;
`endif

    // Tags in flight are unique, so landing and consuming never hit one slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= TAG_W'(NUM_REQ - 1);
            r_out       <= '0;
            r_rsp_valid <= '0;
            r_rsp_le    <= '0;
        end else begin
            r_out       <= r_out & ~w_consume;
            r_rsp_valid <= r_rsp_valid & ~w_consume;
            if (w_gnt_any) begin
                r_ptr            <= w_gnt_idx;
                r_out[w_gnt_idx] <= 1'b1;
            end
            if (w_last.valid) begin
                r_rsp_valid[w_last.idx] <= 1'b1;
                r_rsp_le[w_last.idx]    <= w_le_fin;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_le    = r_rsp_le;
    assign busy      = |r_out;

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_cmp_scheduler
// Description : Directed vectors and multi-cycle sequences for fp_cmp_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_cmp_scheduler;

    localparam int N   = 4;
    localparam int W   = 30;
    localparam int LAT = 3;
`ifdef FP_CMP_SCHED_NAN_EN
    localparam logic NAN_ON = 1'b1;
`else
    localparam logic NAN_ON = 1'b0;
`endif

    localparam logic [29:0] P1  = 30'h13FF0000;
    localparam logic [29:0] P2  = 30'h14000000;
    localparam logic [29:0] M1  = 30'h1BFF0000;
    localparam logic [29:0] M2  = 30'h1C000000;
    localparam logic [29:0] ZR  = 30'h00000000;
    localparam logic [29:0] PI  = 30'h20000000;
    localparam logic [29:0] MI  = 30'h28000000;
    localparam logic [29:0] NN  = 30'h30000000;
    localparam logic [29:0] P1U = 30'h13FF0001;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_le, rsp_ready, rsp_nan;
    logic [N*W-1:0] req_a, req_b;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_cmp_scheduler #(.NUM_REQ(N), .WIDTH(W), .CMP_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_le    (rsp_le),
        .rsp_ready (rsp_ready),
        .rsp_nan   (rsp_nan),
        .busy      (busy)
    );

    typedef struct {
        logic [29:0] a;
        logic [29:0] b;
        logic        le;
        logic        nan;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [29:0] a, input logic [29:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_four();
        set_op(0, P1, P2);
        set_op(1, P2, P1);
        set_op(2, P1, P1);
        set_op(3, M1, P1);
    endtask

    vec_t        vecs [12];
    logic [3:0]  exp_le4 = 4'b1101;
    int          gnt_idx [$];
    int          gnt_cyc [$];
    int          exp_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int          exp_cyc [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

    initial begin
        int   lat;
        logic got_le, got_nan, found, late;
        int   g2, gothers, c;
        logic first_le2, have_le2;

        vecs[0]  = '{P1,  P2, 1'b1, 1'b0};
        vecs[1]  = '{P1,  P1, 1'b1, 1'b0};
        vecs[2]  = '{P2,  P1, 1'b0, 1'b0};
        vecs[3]  = '{M1,  P1, 1'b1, 1'b0};
        vecs[4]  = '{P1,  M1, 1'b0, 1'b0};
        vecs[5]  = '{ZR,  ZR, 1'b1, 1'b0};
        vecs[6]  = '{ZR,  M1, 1'b0, 1'b0};
        vecs[7]  = '{PI,  P1, 1'b0, 1'b0};
        vecs[8]  = '{P1,  PI, 1'b1, 1'b0};
        vecs[9]  = '{MI,  MI, 1'b0, 1'b0};
        vecs[10] = '{NN,  P1, 1'b0, NAN_ON};
        vecs[11] = '{P1U, P1, 1'b0, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_le", rsp_le, 0);
        chk("reset_rsp_nan", rsp_nan, 0);
        chk("reset_busy", busy, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Single requester vectors: latency, result and flag.
        foreach (vecs[v]) begin
            @(negedge clk);
            set_op(0, vecs[v].a, vecs[v].b);
            req_valid = 4'b0001;
            #1;
            chk($sformatf("v%0d_ready", v), req_ready, 4'b0001);
            @(posedge clk);
            found = 1'b0;
            lat   = 0;
            got_le = 1'b0;
            got_nan = 1'b0;
            for (int k = 1; k <= 20 && !found; k++) begin
                @(negedge clk);
                if (k == 1) req_valid = '0;
                if (rsp_valid[0]) begin
                    found   = 1'b1;
                    lat     = k;
                    got_le  = rsp_le[0];
                    got_nan = rsp_nan[0];
                end
            end
            chk($sformatf("v%0d_latency", v), lat, LAT + 1);
            chk($sformatf("v%0d_le", v), got_le, vecs[v].le);
            chk($sformatf("v%0d_nan", v), got_nan, vecs[v].nan);
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Round-robin order with all requesters active.
        do_reset();
        load_four();
        req_valid = '1;
        rsp_ready = '1;
        for (int cy = 0; cy < 14; cy++) begin
            #1;
            chk("rr_onehot", $onehot0(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gnt_idx.push_back(i);
                    gnt_cyc.push_back(cy);
                end
                if (rsp_valid[i]) chk($sformatf("rr_le%0d", i), rsp_le[i], exp_le4[i]);
            end
            @(negedge clk);
        end
        chk("rr_count_ge8", gnt_idx.size() >= 8, 1);
        for (int j = 0; j < 8 && j < gnt_idx.size(); j++) begin
            chk($sformatf("rr_order%0d", j), gnt_idx[j], exp_ord[j]);
            chk($sformatf("rr_cycle%0d", j), gnt_cyc[j], exp_cyc[j]);
        end

        // Requester 2 stalls its response for ten cycles.
        do_reset();
        load_four();
        req_valid = '1;
        rsp_ready = 4'b1011;
        g2 = 0;
        gothers = 0;
        have_le2 = 1'b0;
        first_le2 = 1'b0;
        c = 0;
        for (int cy = 0; cy < 30 && c < 10; cy++) begin
            #1;
            if (req_ready[2]) g2++;
            if (req_ready & 4'b1011) gothers++;
            if (rsp_valid[2]) begin
                if (!have_le2) begin
                    have_le2  = 1'b1;
                    first_le2 = rsp_le[2];
                end
                chk("stall_le2_stable", rsp_le[2], first_le2);
                c++;
            end
            @(negedge clk);
        end
        chk("stall_held_10", c, 10);
        chk("stall_le2_value", first_le2, exp_le4[2]);
        chk("stall_grants2", g2, 1);
        chk("stall_others_run", gothers >= 6, 1);
        chk("stall_rsp2_still", rsp_valid[2], 1);
        req_valid = 4'b0100;
        rsp_ready = '1;
        #1;
        chk("consume_cycle_ready", req_ready, 4'b0000);
        @(negedge clk);
        #1;
        chk("reissue_ready", req_ready, 4'b0100);
        chk("reissue_rsp2_clear", rsp_valid[2], 0);
        @(negedge clk);
        req_valid = '0;

        // Reset with three transactions in flight.
        do_reset();
        load_four();
        req_valid = 4'b0111;
        rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("inflight_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        late = 1'b0;
        for (int cy = 0; cy < 10; cy++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) late = 1'b1;
        end
        chk("no_late_rsp", late, 0);
        req_valid = '1;
        #1;
        chk("post_rst_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fp_cmp_scheduler.md
FP_CMP_SCHEDULER -- requirements
Module: fp_cmp_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one comparator (2..8).
REQ-002 Parameter WIDTH, default 30, FloPoCo word: [29:28] exn (00 zero, 01 normal, 10 inf, 11 NaN), [27] sign, [26:16] exponent (11b), [15:0] fraction (16b).
REQ-003 Parameter CMP_LAT, default 3, fixed pipeline latency in cycles of the shared comparator core (1..8).
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester operand pair valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; transfer when valid and ready are both high.
REQ-008 req_a, req_b  in  NUM_REQ*WIDTH  flattened operands; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-009 rsp_valid  out  NUM_REQ  per-requester result valid.
REQ-010 rsp_le  out  NUM_REQ  result bit: 1 when a <= b.
REQ-011 rsp_ready  in  NUM_REQ  per-requester result consume.
REQ-012 rsp_nan  out  NUM_REQ  operand NaN flag (see Configuration).
REQ-013 busy  out  1  high while any transaction is in flight or any rsp_valid is high.

Function
REQ-014 At most one transfer per cycle; req_ready is one-hot or zero.
REQ-015 Requester i is eligible when req_valid[i] is high and it has no outstanding transaction (in pipe or in unconsumed response register).
REQ-016 Round-robin: search starts at index ptr+1 mod NUM_REQ; after a grant to i, ptr becomes i; ptr unchanged on idle cycles; reset ptr = NUM_REQ-1 so requester 0 wins first.
REQ-017 req_ready is a combinational function of registered state and req_valid only; no dependency on rsp_ready.
REQ-018 Granted operands and a requester tag (clog2 NUM_REQ bits plus valid bit) enter the core and a parallel tag shift register of depth CMP_LAT.
REQ-019 Result bit from core difference R = a - b: le=1 when exn=00, or exn in {01,10} with sign=1; le=0 when exn in {01,10} with sign=0, or exn=11.
REQ-020 Accept at cycle T gives rsp_valid[i] high at cycle T+CMP_LAT+1, holding rsp_le/rsp_nan stable until cycle with rsp_valid[i] and rsp_ready[i].
REQ-021 Response consumed in cycle C: requester i is eligible again in cycle C+1 (no same-cycle reissue).
REQ-022 Back-to-back grants to different requesters every cycle sustain throughput of one comparison per cycle.
REQ-023 Response register writes for different requesters never collide since tags are unique in flight.

Reset
REQ-024 Reset clears tag pipe, outstanding bits, response registers; rsp_valid=0, rsp_le=0, rsp_nan=0, req_ready=0, busy=0, ptr=NUM_REQ-1.
REQ-025 Reset asserted mid-operation discards all in-flight transactions; no response for them after release.
REQ-026 First grant possible in the first clock edge after rst deasserts.

Configuration
REQ-027 Macro FP_CMP_SCHED_NAN_EN defined: operand exn=11 on either input sets rsp_nan=1 and forces rsp_le=0, evaluated at grant and carried in the tag pipe.
REQ-028 Macro undefined: rsp_nan tied 0, no NaN pre-check logic; rsp_le follows REQ-019 only.

Structure
REQ-029 Package fp_cmp_pkg holds WIDTH default, field positions (EXN_HI, EXN_LO, SIGN_BIT), exn encodings (EXN_ZERO, EXN_NORM, EXN_INF, EXN_NAN) and tag width function.
REQ-030 One sub-module fp_le_core: wraps the FloPoCo 11/16 subtractor plus REQ-019 decode, latency CMP_LAT, no stall input; scheduler contains arbiter, tag pipe, response registers.

Verification
REQ-031 Single request: req 0 a=0x13FF0000 (1.0), b=0x14000000 (2.0) at T -> rsp_valid[0] at T+CMP_LAT+1, rsp_le=1.
REQ-032 Equal and greater: a=b=0x13FF0000 -> rsp_le=1; a=0x14000000, b=0x13FF0000 -> rsp_le=0.
REQ-033 All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; one grant per cycle after each requester's response consumed.
REQ-034 Requester 2 holds rsp_ready=0 for 10 cycles -> no second grant to 2, others continue, rsp_le[2] stable, reissue one cycle after consume.
REQ-035 With FP_CMP_SCHED_NAN_EN: a=0x30000000 (NaN), b=0x13FF0000 -> rsp_nan=1, rsp_le=0; without macro rsp_nan=0.
REQ-036 rst pulse with 3 transactions in flight -> all rsp_valid=0, busy=0, no late responses; next grant to requester 0.
